// File: rtl/pwm_ramp_ctrl.sv
// Speed/direction sequencer for one drive motor: ramps the pwm duty code toward
// a commanded target, inserting a braked dead time around every direction reversal.
module pwm_ramp_ctrl #(
  parameter int PW_W     = 3,
  parameter int MAX_PW   = 5,
  parameter int RAMP_DIV = 16,
  parameter int DEAD_CYC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [PW_W-1:0] cmd_speed,
  input  logic            cmd_dir,
  input  logic            estop,
  output logic [PW_W-1:0] pulse_width,
  output logic            dir,
  output logic            brake,
  output logic            at_target
);

  localparam int RW = $clog2(RAMP_DIV);
  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam logic [PW_W-1:0] MAX_CODE = PW_W'(MAX_PW);

  typedef enum logic [1:0] {RUN, DEAD, ESTOP} state_t;

  state_t          state;
  logic [PW_W-1:0] tgt_speed;
  logic            tgt_dir;
  logic [RW-1:0]   ramp_cnt;
  logic [DW-1:0]   dead_cnt;
  logic [PW_W-1:0] sat_speed;
  logic [PW_W-1:0] desired;

  assign cmd_ready = (state != ESTOP);
  assign at_target = (state == RUN) && (pulse_width == tgt_speed) && (dir == tgt_dir);
  assign sat_speed = (cmd_speed > MAX_CODE) ? MAX_CODE : cmd_speed;
  // A pending reversal first drives the duty down to zero.
  assign desired   = (dir != tgt_dir) ? '0 : tgt_speed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      tgt_speed   <= '0;
      tgt_dir     <= 1'b0;
      ramp_cnt    <= '0;
      dead_cnt    <= '0;
      pulse_width <= '0;
      dir         <= 1'b0;
      brake       <= 1'b0;
    end else if (estop) begin
      state       <= ESTOP;
      tgt_speed   <= '0;
      ramp_cnt    <= '0;
      dead_cnt    <= '0;
      pulse_width <= '0;
      brake       <= 1'b1;
    end else begin
      if (cmd_valid && cmd_ready) begin
        tgt_speed <= sat_speed;
        tgt_dir   <= cmd_dir;
      end
      unique case (state)
        RUN: begin
          if (pulse_width == desired) begin
            ramp_cnt <= '0;
            if (dir != tgt_dir) begin
              state    <= DEAD;
              brake    <= 1'b1;
              dead_cnt <= '0;
            end
          end else if (ramp_cnt == RW'(RAMP_DIV - 1)) begin
            ramp_cnt    <= '0;
            pulse_width <= (pulse_width < desired) ? pulse_width + 1'b1 : pulse_width - 1'b1;
          end else begin
            ramp_cnt <= ramp_cnt + 1'b1;
          end
        end
        DEAD: begin
          pulse_width <= '0;
          brake       <= 1'b1;
          // Dead time always runs to completion; late commands only move the target.
          if (dead_cnt == DW'(DEAD_CYC - 1)) begin
            dead_cnt <= '0;
            dir      <= tgt_dir;
            brake    <= 1'b0;
            state    <= RUN;
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        ESTOP: begin
          brake <= 1'b0;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Speed/direction sequencer for one smart-car drive motor, sitting between the motion-command logic and the `pwm` generator. It accepts speed/direction commands over a valid/ready handshake and ramps the `pwm` `pulse_width` one step at a time toward the target. Direction reversals ramp to zero, apply a braked dead time, flip `dir`, then ramp back up. An emergency-stop input overrides everything.

## Interface
- `PW_W`, 3: width of `pulse_width`; matches the `pwm` input.
- `MAX_PW`, 5: largest legal duty code; commands above it saturate to it.
- `RAMP_DIV`, 16: clocks per one-LSB `pulse_width` step, ≥2.
- `DEAD_CYC`, 8: clocks `brake` is held during a reversal, ≥1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted.
- `cmd_speed`  in  `PW_W`  target duty code.
- `cmd_dir`  in  1  target direction (0 = forward).
- `estop`  in  1  emergency stop, level-sensitive.
- `pulse_width`  out  `PW_W`  duty code to `pwm.pulse_width`; registered.
- `dir`  out  1  H-bridge direction; registered.
- `brake`  out  1  H-bridge brake; registered.
- `at_target`  out  1  duty and direction both equal the target.

## Operation
- Priority, highest first: `rst`, then `estop`, then state behaviour and command accept.
- Internal registers: `tgt_speed`, `tgt_dir`, `ramp_cnt`, `dead_cnt`, and state ∈ {RUN, DEAD, ESTOP}.
- Accept:
  - A command is accepted when `cmd_valid && cmd_ready`.
  - `tgt_speed <= min(cmd_speed, MAX_PW)` and `tgt_dir <= cmd_dir`.
  - The new target is used from the next cycle.
  - A new command may overwrite the target at any time outside ESTOP; there is no queue.
- `cmd_ready = (state != ESTOP)`, combinational.
- RUN:
  - desired = (`dir != tgt_dir`) ? 0 : `tgt_speed`.
  - If `pulse_width == desired`:
    - `ramp_cnt <= 0`.
    - If additionally `dir != tgt_dir` (so `pulse_width` is 0), go to DEAD with `brake <= 1` and `dead_cnt <= 0`.
  - Otherwise:
    - If `ramp_cnt == RAMP_DIV-1`: `pulse_width` steps ±1 toward desired and `ramp_cnt <= 0`.
    - Else `ramp_cnt` increments.
  - `pulse_width` never jumps by more than 1 per step, never exceeds `MAX_PW`, and never wraps below 0.
  - A target change mid-ramp does not reset `ramp_cnt`.
- DEAD:
  - `pulse_width` = 0 and `brake` = 1; `dead_cnt` increments.
  - At `dead_cnt == DEAD_CYC-1`: `dir <= tgt_dir`, `brake <= 0`, go to RUN.
  - A command arriving during DEAD updates the target but never shortens the dead time.
- ESTOP:
  - Entry: `estop` high in any state. On the next edge `pulse_width <= 0`, `brake <= 1`, `tgt_speed <= 0`, `ramp_cnt`/`dead_cnt` <= 0, state ESTOP.
  - While `estop` stays high: hold all of the above.
  - Exit: on the first edge with `estop` low, `brake <= 0` and go to RUN.
  - `dir` and `tgt_dir` are unchanged by ESTOP.
- `at_target = (state == RUN) && pulse_width == tgt_speed && dir == tgt_dir`, combinational.

## Timing
- Reset values:
  - Outputs: `pulse_width` 0, `dir` 0, `brake` 0, `cmd_ready` 1, `at_target` 1.
  - Internals: `tgt_speed` 0, `tgt_dir` 0, counters 0, state RUN.
- Asserting `rst` mid-operation (including mid-DEAD or mid-ESTOP) returns all registers to their reset values on that edge.
- Ramp-up latency:
  - For a command accepted on edge N with `ramp_cnt` 0, the first step appears after edge N+`RAMP_DIV`.
  - Step k appears after edge N+k·`RAMP_DIV`.
- Reversal from duty s, accepted on edge N:
  - `pulse_width` reaches 0 after edge N+s·`RAMP_DIV`.
  - `brake` rises on the following edge.
  - `brake` stays high exactly `DEAD_CYC` cycles.
  - `dir` flips on the same edge `brake` falls.
  - Ramp-up then restarts with `ramp_cnt` 0.
- `estop` takes effect on the first edge it is sampled high: one-cycle latency to `pulse_width` 0.

## Test plan
Bench parameters: `RAMP_DIV`=4, `DEAD_CYC`=3, `MAX_PW`=5.
1. Reset: hold `rst` 3 cycles, then release. Outputs must be `pulse_width` 0, `dir` 0, `brake` 0, `cmd_ready` 1, `at_target` 1.
2. Ramp up: command speed 5, dir 0, accepted on edge N. `pulse_width` must read 1,2,3,4,5 after edges N+4, N+8, N+12, N+16, N+20. `at_target` rises with 5.
3. Saturation and retarget:
   - Command speed 7 → `tgt_speed` 5.
   - Mid-ramp at `pulse_width` 3, command speed 1 → the next step goes to 2, then 1, each 4 cycles apart.
4. Reversal: at speed 2 with dir 0, command speed 2 with dir 1 on edge N.
   - `pulse_width` 1 after N+4, 0 after N+8.
   - `brake` high for edges N+9..N+11; `dir` 1 and `brake` 0 after N+12.
   - `pulse_width` 1 after N+16, 2 after N+20.
5. ESTOP: assert `estop` for 5 cycles at `pulse_width` 4.
   - Next edge: `pulse_width` 0, `brake` 1, `cmd_ready` 0.
   - Pulsing `cmd_valid` during ESTOP is ignored.
   - After release: `brake` 0, target 0, duty stays 0.
6. Reset mid-DEAD: assert `rst` while `brake`=1. The next edge must show all reset values, and no `dir` flip occurs.
